// File: rtl/tlc_phase_monitor.sv
// ---------------------------------------------------------------------------
// tlc_phase_monitor
//
// Receive-side conformance monitor for the traffic-light controller. It
// decodes the six 2-bit light outputs back into a phase index 0..9. It then
// checks three things against the nominal rotation P0 -> P1 -> ... -> P9 -> P0:
//   - the order in which phases follow each other,
//   - how long each phase is held (dwell),
//   - whether the light pattern is legal at all.
// Violations are reported as sticky error bits plus a one-cycle pulse.
//
// Ports
//   clk          in   1  clock, all logic on rising edge
//   rst          in   1  synchronous active-high reset
//   light_M1..S  in   2  light codes: 10=green, 01=yellow, 00=red, 11=illegal
//   clr_err      in   1  one-cycle pulse, clears the sticky error flags
//   phase        out  4  registered decoded phase 0..9, 4'hF = none
//   phase_valid  out  1  phase holds a legal value
//   locked       out  1  a legal transition was seen, timing is being checked
//   dwell        out  5  cycles the current phase has been held (saturates 31)
//   cycle_cnt    out  8  completed rotations while locked (wraps)
//   err_pattern  out  1  sticky: illegal or unknown light pattern
//   err_seq      out  1  sticky: transition other than p -> (p+1) mod 10
//   err_time     out  1  sticky: dwell too short or too long
//   err_pulse    out  1  one-cycle pulse on any new error event
// ---------------------------------------------------------------------------
module tlc_phase_monitor #(
  parameter int unsigned TMG = 10,  // main-green terminal count
  parameter int unsigned TTG = 7,   // turn-green terminal count
  parameter int unsigned TSG = 5,   // side-green terminal count
  parameter int unsigned TY  = 3    // yellow terminal count
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] light_M1,
  input  logic [1:0] light_M2,
  input  logic [1:0] light_M3,
  input  logic [1:0] light_M4,
  input  logic [1:0] light_R,
  input  logic [1:0] light_S,
  input  logic       clr_err,
  output logic [3:0] phase,
  output logic       phase_valid,
  output logic       locked,
  output logic [4:0] dwell,
  output logic [7:0] cycle_cnt,
  output logic       err_pattern,
  output logic       err_seq,
  output logic       err_time,
  output logic       err_pulse
);

  localparam logic [1:0] LR = 2'b00;
  localparam logic [1:0] LY = 2'b01;
  localparam logic [1:0] LG = 2'b10;
  localparam logic [3:0] PH_NONE = 4'hF;
  localparam logic [4:0] DWELL_MAX = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  // Nominal dwell (terminal count + 1) of each phase.
  function automatic logic [4:0] f_expected(input logic [3:0] p);
    logic [4:0] v;
    case (p)
      4'd0:       v = 5'(TMG + 1);
      4'd2, 4'd4: v = 5'(TTG + 1);
      4'd6, 4'd8: v = 5'(TSG + 1);
      default:    v = 5'(TY + 1);
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------
  // Combinational pattern decode. A light at 11 never matches a legal
  // entry, so it falls through to PH_NONE with the unknown combinations.
  // ---------------------------------------------------------------------
  logic [11:0] w_lights;
  logic [3:0]  w_dec;

  assign w_lights = {light_M1, light_M2, light_M3, light_M4, light_R, light_S};

  always_comb begin
    w_dec = PH_NONE;
    case (w_lights)
      {LG, LG, LR, LR, LR, LR}: w_dec = 4'd0;
      {LG, LY, LR, LR, LR, LR}: w_dec = 4'd1;
      {LG, LR, LG, LR, LR, LR}: w_dec = 4'd2;
      {LY, LR, LY, LR, LR, LR}: w_dec = 4'd3;
      {LR, LG, LR, LG, LR, LR}: w_dec = 4'd4;
      {LR, LY, LR, LY, LR, LR}: w_dec = 4'd5;
      {LR, LR, LR, LR, LG, LR}: w_dec = 4'd6;
      {LR, LR, LR, LR, LY, LR}: w_dec = 4'd7;
      {LR, LR, LR, LR, LR, LG}: w_dec = 4'd8;
      {LR, LR, LR, LR, LR, LY}: w_dec = 4'd9;
      default:                  w_dec = PH_NONE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  state_t      r_state;
  logic [3:0]  r_phase;
  logic        r_phase_valid;
  logic        r_locked;
  logic [4:0]  r_dwell;
  logic [7:0]  r_cycle_cnt;
  logic        r_err_pattern;
  logic        r_err_seq;
  logic        r_err_time;
  logic        r_err_pulse;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  state_t      w_state_next;
  logic [3:0]  w_phase_next;
  logic [4:0]  w_dwell_next;
  logic [7:0]  w_cycle_cnt_next;
  logic        w_new_pattern;
  logic        w_new_seq;
  logic        w_new_time;
  logic [3:0]  w_succ;
  logic [4:0]  w_dwell_inc;
  logic [4:0]  w_expected;

  assign w_succ      = (r_phase == 4'd9) ? 4'd0 : r_phase + 4'd1;
  assign w_dwell_inc = (r_dwell == DWELL_MAX) ? DWELL_MAX : r_dwell + 5'd1;
  assign w_expected  = f_expected(r_phase);

  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_dwell_next     = r_dwell;
    w_cycle_cnt_next = r_cycle_cnt;
    w_new_pattern    = 1'b0;
    w_new_seq        = 1'b0;
    w_new_time       = 1'b0;

    if (w_dec == PH_NONE) begin
      // Unknown pattern: only an error once we were following a phase.
      w_new_pattern = (r_state != S_IDLE);
      w_state_next  = S_IDLE;
      w_phase_next  = PH_NONE;
      w_dwell_next  = 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_phase_next = w_dec;
          w_dwell_next = 5'd1;
          w_state_next = S_SYNC;
        end

        // First phase seen is of unknown age, so its dwell is not judged.
        S_SYNC: begin
          if (w_dec == r_phase) begin
            w_dwell_next = w_dwell_inc;
          end else if (w_dec == w_succ) begin
            w_phase_next = w_dec;
            w_dwell_next = 5'd1;
            w_state_next = S_TRACK;
          end else begin
            w_new_seq    = 1'b1;
            w_phase_next = w_dec;
            w_dwell_next = 5'd1;
          end
        end

        S_TRACK: begin
          if (w_dec == r_phase) begin
            // Overrun flagged exactly once, at the edge dwell passes nominal.
            w_new_time   = (r_dwell == w_expected);
            w_dwell_next = w_dwell_inc;
          end else if (w_dec == w_succ) begin
            w_new_time   = (r_dwell < w_expected);
            w_phase_next = w_dec;
            w_dwell_next = 5'd1;
            if (r_phase == 4'd9) begin
              w_cycle_cnt_next = r_cycle_cnt + 8'd1;
            end
          end else begin
            // Out-of-order jump: resynchronise, no timing verdict on it.
            w_new_seq    = 1'b1;
            w_phase_next = w_dec;
            w_dwell_next = 5'd1;
            w_state_next = S_SYNC;
          end
        end

        default: begin
          w_state_next = S_IDLE;
          w_phase_next = PH_NONE;
          w_dwell_next = 5'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Registers. A new error in the same cycle as clr_err leaves its bit set.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_phase       <= PH_NONE;
      r_phase_valid <= 1'b0;
      r_locked      <= 1'b0;
      r_dwell       <= 5'd0;
      r_cycle_cnt   <= 8'd0;
      r_err_pattern <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_time    <= 1'b0;
      r_err_pulse   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_phase       <= w_phase_next;
      r_phase_valid <= (w_phase_next != PH_NONE);
      r_locked      <= (w_state_next == S_TRACK);
      r_dwell       <= w_dwell_next;
      r_cycle_cnt   <= w_cycle_cnt_next;
      r_err_pattern <= (r_err_pattern & ~clr_err) | w_new_pattern;
      r_err_seq     <= (r_err_seq & ~clr_err) | w_new_seq;
      r_err_time    <= (r_err_time & ~clr_err) | w_new_time;
      r_err_pulse   <= w_new_pattern | w_new_seq | w_new_time;
    end
  end

  assign phase       = r_phase;
  assign phase_valid = r_phase_valid;
  assign locked      = r_locked;
  assign dwell       = r_dwell;
  assign cycle_cnt   = r_cycle_cnt;
  assign err_pattern = r_err_pattern;
  assign err_seq     = r_err_seq;
  assign err_time    = r_err_time;
  assign err_pulse   = r_err_pulse;

endmodule

// File: tb/tb_tlc_phase_monitor.sv
// ---------------------------------------------------------------------------
// tb_tlc_phase_monitor
//
// Directed scenarios followed by randomized light sequences. A reference
// model tracks the rules of the monitor in plain integers, and every output
// is compared at each falling edge. Named checks at key points pin down
// the expected values of the directed scenarios.
// ---------------------------------------------------------------------------
module tb_tlc_phase_monitor;

  localparam int TMG = 10;
  localparam int TTG = 7;
  localparam int TSG = 5;
  localparam int TY  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] light_M1 = 2'b00, light_M2 = 2'b00, light_M3 = 2'b00;
  logic [1:0] light_M4 = 2'b00, light_R = 2'b00, light_S = 2'b00;
  logic       clr_err = 1'b0;
  logic [3:0] phase;
  logic       phase_valid, locked;
  logic [4:0] dwell;
  logic [7:0] cycle_cnt;
  logic       err_pattern, err_seq, err_time, err_pulse;

  always #5 clk = ~clk;

  tlc_phase_monitor #(.TMG(TMG), .TTG(TTG), .TSG(TSG), .TY(TY)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .light_M1    (light_M1),
    .light_M2    (light_M2),
    .light_M3    (light_M3),
    .light_M4    (light_M4),
    .light_R     (light_R),
    .light_S     (light_S),
    .clr_err     (clr_err),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .dwell       (dwell),
    .cycle_cnt   (cycle_cnt),
    .err_pattern (err_pattern),
    .err_seq     (err_seq),
    .err_time    (err_time),
    .err_pulse   (err_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] Y = 2'b01;

  // Light pattern of phase p, built from the per-light table.
  function automatic logic [11:0] pat(input int p);
    logic [1:0] m1, m2, m3, m4, r, s;
    m1 = 2'b00; m2 = 2'b00; m3 = 2'b00; m4 = 2'b00; r = 2'b00; s = 2'b00;
    case (p)
      0: begin m1 = G; m2 = G; end
      1: begin m1 = G; m2 = Y; end
      2: begin m1 = G; m3 = G; end
      3: begin m1 = Y; m3 = Y; end
      4: begin m2 = G; m4 = G; end
      5: begin m2 = Y; m4 = Y; end
      6: r = G;
      7: r = Y;
      8: s = G;
      default: s = Y;
    endcase
    return {m1, m2, m3, m4, r, s};
  endfunction

  function automatic int decode(input logic [11:0] v);
    for (int k = 0; k < 10; k++) begin
      if (v == pat(k)) return k;
    end
    return -1;
  endfunction

  function automatic int exp_dwell(input int p);
    if (p == 0) return TMG + 1;
    if (p == 2 || p == 4) return TTG + 1;
    if (p == 6 || p == 8) return TSG + 1;
    return TY + 1;
  endfunction

  int m_phase = -1;   // -1: no phase being followed
  int m_dwell = 0;
  int m_cnt   = 0;
  bit m_locked = 0;
  bit m_ep = 0, m_es = 0, m_et = 0, m_pulse = 0;

  task automatic model_step(input logic [11:0] v, input bit c, input bit r);
    int d;
    bit np, ns, nt;
    if (r) begin
      m_phase = -1; m_dwell = 0; m_cnt = 0; m_locked = 0;
      m_ep = 0; m_es = 0; m_et = 0; m_pulse = 0;
      return;
    end
    d = decode(v);
    np = 0; ns = 0; nt = 0;
    if (d < 0) begin
      np = (m_phase >= 0);
      m_phase = -1; m_dwell = 0; m_locked = 0;
    end else if (m_phase < 0) begin
      m_phase = d; m_dwell = 1;
    end else if (d == m_phase) begin
      if (m_locked && m_dwell == exp_dwell(m_phase)) nt = 1;
      m_dwell = (m_dwell < 31) ? m_dwell + 1 : 31;
    end else if (d == (m_phase + 1) % 10) begin
      if (m_locked && m_dwell < exp_dwell(m_phase)) nt = 1;
      if (m_locked && m_phase == 9) m_cnt = (m_cnt + 1) % 256;
      m_phase = d; m_dwell = 1; m_locked = 1;
    end else begin
      ns = 1;
      m_phase = d; m_dwell = 1; m_locked = 0;
    end
    m_ep = (m_ep && !c) || np;
    m_es = (m_es && !c) || ns;
    m_et = (m_et && !c) || nt;
    m_pulse = np || ns || nt;
  endtask

  task automatic compare_all();
    check_val("phase",       phase,       (m_phase < 0) ? 15 : m_phase);
    check_val("phase_valid", phase_valid, m_phase >= 0);
    check_val("locked",      locked,      m_locked);
    check_val("dwell",       dwell,       m_dwell);
    check_val("cycle_cnt",   cycle_cnt,   m_cnt);
    check_val("err_pattern", err_pattern, m_ep);
    check_val("err_seq",     err_seq,     m_es);
    check_val("err_time",    err_time,    m_et);
    check_val("err_pulse",   err_pulse,   m_pulse);
  endtask

  // One clock: drive, let the edge happen, advance model, compare at negedge.
  task automatic tick(input logic [11:0] v, input bit c, input bit r);
    {light_M1, light_M2, light_M3, light_M4, light_R, light_S} = v;
    clr_err = c;
    rst = r;
    @(posedge clk);
    model_step(v, c, r);
    @(negedge clk);
    compare_all();
    clr_err = 1'b0;
    rst = 1'b0;
  endtask

  task automatic hold(input int p, input int n, input int clr_at, input bit quiet);
    for (int i = 0; i < n; i++) tick(pat(p), (i == clr_at), 1'b0);
    if (!quiet)
      $display("hold P%0d x%0d -> phase=%0d dwell=%0d locked=%0d cnt=%0d err=%b%b%b",
               p, n, phase, dwell, locked, cycle_cnt, err_pattern, err_seq, err_time);
  endtask

  task automatic rotation(input bit quiet);
    for (int p = 0; p < 10; p++) hold(p, exp_dwell(p), -1, quiet);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] v;
    int cur, p, len, kind, j;

    // Reset
    tick(pat(0), 1'b0, 1'b1);
    tick(pat(0), 1'b0, 1'b1);
    $display("reset -> phase=%0d valid=%0d locked=%0d", phase, phase_valid, locked);
    check_val("rst_phase", phase, 15);
    check_val("rst_valid", phase_valid, 0);
    check_val("rst_errs", {err_pattern, err_seq, err_time, err_pulse}, 0);

    // 1: ideal rotations
    hold(0, 11, -1, 0);
    tick(pat(1), 1'b0, 1'b0);
    check_val("t1_lock", locked, 1);
    check_val("t1_phase", phase, 1);
    hold(1, 3, -1, 0);
    for (int q = 2; q < 10; q++) hold(q, exp_dwell(q), -1, 0);
    rotation(0);
    rotation(0);
    tick(pat(0), 1'b0, 1'b0);
    check_val("t1_cnt", cycle_cnt, 3);
    check_val("t1_errs", {err_pattern, err_seq, err_time}, 0);
    hold(0, 10, -1, 0);
    hold(1, 4, -1, 0);
    hold(2, 8, -1, 0);

    // 2: skip P3
    tick(pat(4), 1'b0, 1'b0);
    $display("skip P2->P4 -> seq=%0d pulse=%0d locked=%0d", err_seq, err_pulse, locked);
    check_val("t2_seq", err_seq, 1);
    check_val("t2_pulse", err_pulse, 1);
    check_val("t2_lock", locked, 0);
    check_val("t2_phase", phase, 4);
    hold(4, 7, -1, 0);
    tick(pat(5), 1'b0, 1'b0);
    check_val("t2_relock", locked, 1);
    check_val("t2_time", err_time, 0);

    // 6a: clear with no new error
    tick(pat(5), 1'b1, 1'b0);
    $display("clr_err -> err=%b%b%b cnt=%0d", err_pattern, err_seq, err_time, cycle_cnt);
    check_val("t6_clr_errs", {err_pattern, err_seq, err_time, err_pulse}, 0);
    check_val("t6_clr_cnt", cycle_cnt, 3);
    check_val("t6_clr_dwell", dwell, 2);
    hold(5, 2, -1, 0);
    for (int q = 6; q < 10; q++) hold(q, exp_dwell(q), -1, 0);

    // 3: short P0
    hold(0, 10, -1, 0);
    tick(pat(1), 1'b0, 1'b0);
    $display("short P0 -> time=%0d seq=%0d", err_time, err_seq);
    check_val("t3_time", err_time, 1);
    check_val("t3_seq", err_seq, 0);
    check_val("t3_pulse", err_pulse, 1);
    hold(1, 3, -1, 0);
    hold(2, 8, -1, 0);
    hold(3, 4, -1, 0);
    hold(4, 8, -1, 0);
    hold(5, 4, 0, 0);

    // 4: long P6
    for (int i = 0; i < 9; i++) begin
      tick(pat(6), 1'b0, 1'b0);
      check_val("t4_pulse", err_pulse, (i == 6));
    end
    $display("long P6 -> dwell=%0d time=%0d", dwell, err_time);
    check_val("t4_dwell", dwell, 9);
    check_val("t4_time", err_time, 1);
    tick(pat(7), 1'b0, 1'b0);
    check_val("t4_p7_pulse", err_pulse, 0);
    hold(7, 3, -1, 0);
    hold(8, 6, -1, 0);
    hold(9, 4, -1, 0);

    // 5: illegal pattern, then resync
    tick({G, 2'b00, 2'b00, G, 2'b00, 2'b00}, 1'b0, 1'b0);
    $display("bad pattern -> pat=%0d phase=%0d", err_pattern, phase);
    check_val("t5_pat", err_pattern, 1);
    check_val("t5_phase", phase, 15);
    check_val("t5_valid", phase_valid, 0);
    check_val("t5_lock", locked, 0);
    tick(pat(3), 1'b0, 1'b0);
    check_val("t5_sync_lock", locked, 0);
    tick(pat(4), 1'b0, 1'b0);
    check_val("t5_relock", locked, 1);
    hold(4, 7, -1, 0);
    hold(5, 4, -1, 0);
    hold(6, 1, -1, 0);

    // 6b: clear coincides with a skip
    tick(pat(8), 1'b1, 1'b0);
    $display("clr+skip -> err=%b%b%b pulse=%0d", err_pattern, err_seq, err_time, err_pulse);
    check_val("t6_skip_seq", err_seq, 1);
    check_val("t6_skip_pat", err_pattern, 0);
    check_val("t6_skip_time", err_time, 0);
    check_val("t6_skip_pulse", err_pulse, 1);
    hold(9, 4, -1, 0);
    for (int q = 0; q < 4; q++) hold(q, exp_dwell(q), -1, 0);
    hold(4, 3, -1, 0);

    // 6c: reset mid-P4
    tick(pat(4), 1'b0, 1'b1);
    $display("reset mid-P4 -> phase=%0d dwell=%0d cnt=%0d", phase, dwell, cycle_cnt);
    check_val("t6_rst_phase", phase, 15);
    check_val("t6_rst_misc", {phase_valid, locked, dwell, cycle_cnt}, 0);
    check_val("t6_rst_errs", {err_pattern, err_seq, err_time, err_pulse}, 0);

    // Rotation counter wrap
    for (int k = 0; k < 256; k++) begin
      rotation(1);
      $display("rotation %0d -> cnt=%0d", k, cycle_cnt);
    end
    check_val("wrap_255", cycle_cnt, 255);
    tick(pat(0), 1'b0, 1'b0);
    check_val("wrap_0", cycle_cnt, 0);

    // Randomized segments
    cur = 0;
    for (int seg = 0; seg < 300; seg++) begin
      kind = $urandom_range(0, 99);
      if (kind < 65) begin
        p = (cur < 0) ? 0 : (cur + 1) % 10;
        j = $urandom_range(0, 5);
        len = exp_dwell(p);
        if (j == 0) len = len - 1;
        else if (j == 4) len = len + 1;
        else if (j == 5) len = len + $urandom_range(2, 25);
      end else if (kind < 85) begin
        p = $urandom_range(0, 9);
        len = $urandom_range(1, 16);
      end else begin
        p = -1;
        len = $urandom_range(1, 3);
      end
      for (int i = 0; i < len; i++) begin
        if (p < 0) begin
          v = 12'($urandom);
          if (decode(v) >= 0) v[11:10] = 2'b11;
        end else begin
          v = pat(p);
        end
        tick(v, ($urandom_range(0, 19) == 0), ($urandom_range(0, 399) == 0));
      end
      cur = p;
      $display("seg %0d: P%0d x%0d -> phase=%0d dwell=%0d locked=%0d cnt=%0d err=%b%b%b",
               seg, p, len, phase, dwell, locked, cycle_cnt, err_pattern, err_seq, err_time);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
